led_panel_scanner: RTL and testbench

LED_PANEL_SCANNER -- requirements
Module: led_panel_scanner

---
 rtl/led_panel_scanner.sv | 185 ++++++++++++++++++
 tb/tb_led_panel_scanner.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_panel_scanner.sv
// Double-buffered row-scan driver for parallel HUB-style LED panels; banks swap only at frame end.
// Define TEST_PATTERN_EN to compile in the all-on test pattern driven by test_mode.
module led_panel_scanner #(
  parameter int NUM_PANELS   = 4,
  parameter int COLORS       = 3,
  parameter int ROWS         = 16,
  parameter int COLS         = 16,
  parameter int CLK_DIV      = 4,
  parameter int BLANK_CYCLES = 8,
  parameter int ON_CYCLES    = 1024,
  localparam int PW    = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int W     = COLORS * COLS,
  localparam int LANES = NUM_PANELS * COLORS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_panel,
  input  logic [RW-1:0]    wr_row,
  input  logic [W-1:0]     wr_data,
  input  logic             swap_req,
  input  logic             test_mode,
  output logic             serial_clk,
  output logic [LANES-1:0] serial_data_out,
  output logic             latch_enable,
  output logic             output_enable_n,
  output logic [ROWS-1:0]  row_select_n,
  output logic             swap_pending,
  output logic             frame_start,
  output logic [2:0]       state_dbg
);

  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW   = $clog2(2 * CLK_DIV) > 0 ? $clog2(2 * CLK_DIV) : 1;
  localparam int TMAX = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int AW   = 1 + PW + RW;

  typedef enum logic [2:0] {SHIFT, BLANK_PRE, LATCH, BLANK_POST, DISPLAY} state_t;

  state_t          state, state_next;
  logic            run;
  logic [DW-1:0]   div_cnt;
  logic [CW-1:0]   col_cnt;
  logic [TW-1:0]   tmr;
  logic [RW-1:0]   row_cnt;
  logic            front_bank;
  logic            oe_n_q;
  logic [ROWS-1:0] row_sel_q;
  logic            tp_q;
  logic [W-1:0]    mem [2**AW];

  logic bit_done, shift_done, blank_done, on_done, row_wrap, frame_end;
  logic shifting, panel_ok, row_ok;

  assign bit_done   = (div_cnt == DW'(2 * CLK_DIV - 1));
  assign shift_done = bit_done && (col_cnt == '0);
  assign blank_done = (tmr == TW'(BLANK_CYCLES - 1));
  assign on_done    = (tmr == TW'(ON_CYCLES - 1));
  assign row_wrap   = (row_cnt == RW'(ROWS - 1));
  assign frame_end  = (state == DISPLAY) && on_done && row_wrap;
  // run holds the scanner idle for one cycle after reset so no output pulses while reset is held
  assign shifting   = run && (state == SHIFT);

  if (NUM_PANELS == (1 << PW)) begin : g_panel_full
    assign panel_ok = 1'b1;
  end else begin : g_panel_chk
    assign panel_ok = (wr_panel < PW'(NUM_PANELS));
  end

  if (ROWS == (1 << RW)) begin : g_row_full
    assign row_ok = 1'b1;
  end else begin : g_row_chk
    assign row_ok = (wr_row < RW'(ROWS));
  end

  // wr_en is a one-cycle strobe with no backpressure; the write always lands in the back bank
  always_ff @(posedge clk) begin
    if (wr_en && panel_ok && row_ok) begin
      mem[{~front_bank, wr_panel, wr_row}] <= wr_data;
    end
  end

  always_comb begin
    state_next = state;
    if (run) begin
      case (state)
        SHIFT:      if (shift_done) state_next = BLANK_PRE;
        BLANK_PRE:  if (blank_done) state_next = LATCH;
        LATCH:      state_next = BLANK_POST;
        BLANK_POST: if (blank_done) state_next = DISPLAY;
        DISPLAY:    if (on_done)    state_next = SHIFT;
        default:    state_next = SHIFT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SHIFT;
      run          <= 1'b0;
      div_cnt      <= '0;
      col_cnt      <= CW'(COLS - 1);
      tmr          <= '0;
      row_cnt      <= '0;
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
      oe_n_q       <= 1'b1;
      row_sel_q    <= '1;
    end else begin
      run   <= 1'b1;
      state <= state_next;

      case (state)
        SHIFT: begin
          if (run) begin
            if (bit_done) begin
              div_cnt <= '0;
              col_cnt <= shift_done ? CW'(COLS - 1) : col_cnt - 1'b1;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
        default: tmr <= (state_next != state) ? '0 : tmr + 1'b1;
      endcase

      if ((state == DISPLAY) && on_done) begin
        row_cnt <= row_wrap ? '0 : row_cnt + 1'b1;
      end

      // a request arriving on the frame-end edge itself still takes effect on that edge
      if (frame_end && (swap_pending || swap_req)) begin
        front_bank   <= ~front_bank;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end

      // OE holds through SHIFT so the previous row keeps glowing while the next one loads
      case (state_next)
        BLANK_PRE, LATCH, BLANK_POST: oe_n_q <= 1'b1;
        DISPLAY:                      oe_n_q <= 1'b0;
        default:                      oe_n_q <= oe_n_q;
      endcase

      if ((state_next == LATCH) && (state != LATCH)) begin
        row_sel_q <= ~(ROWS'(1) << row_cnt);
      end
    end
  end

`ifdef TEST_PATTERN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tp_q <= 1'b0;
    end else if (!run || ((state == DISPLAY) && on_done)) begin
      tp_q <= test_mode;
    end
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign tp_q = 1'b0;
`endif

  for (genvar p = 0; p < NUM_PANELS; p++) begin : g_panel
    logic [W-1:0] rd_word;
    assign rd_word = mem[{front_bank, PW'(p), row_cnt}];
    for (genvar c = 0; c < COLORS; c++) begin : g_color
      logic [COLS-1:0] lane_word;
      assign lane_word = rd_word[c*COLS +: COLS];
      assign serial_data_out[p*COLORS + c] = shifting && (lane_word[col_cnt] || tp_q);
    end
  end

  assign serial_clk      = shifting && (div_cnt >= DW'(CLK_DIV));
  assign latch_enable    = (state == LATCH);
  assign output_enable_n = oe_n_q;
  assign row_select_n    = row_sel_q;
  assign frame_start     = shifting && (row_cnt == '0) && (col_cnt == CW'(COLS - 1)) && (div_cnt == '0);
  assign state_dbg       = state;

endmodule

// File: tb/tb_led_panel_scanner.sv
// Bench for led_panel_scanner: bank model plus expected-lane queue checked at serial_clk rises.
// ON_CYCLES is shortened so a full frame stays short; all other parameters are defaults.
module tb_led_panel_scanner;

  localparam int NUM_PANELS   = 4;
  localparam int COLORS       = 3;
  localparam int ROWS         = 16;
  localparam int COLS         = 16;
  localparam int CLK_DIV      = 4;
  localparam int BLANK_CYCLES = 8;
  localparam int ON_CYCLES    = 64;
  localparam int PW           = 2;
  localparam int RW           = 4;
  localparam int W            = COLORS * COLS;
  localparam int LANES        = NUM_PANELS * COLORS;
  localparam int SHIFT_CYC    = 2 * CLK_DIV * COLS;
  localparam int LATCH_OFF    = SHIFT_CYC + BLANK_CYCLES;
  localparam int DISP_OFF     = LATCH_OFF + 1 + BLANK_CYCLES;
  localparam int ROW_CYC      = DISP_OFF + ON_CYCLES;
  localparam int FRAME_CYC    = ROW_CYC * ROWS;

  logic             clk, reset, wr_en, swap_req, test_mode;
  logic [PW-1:0]    wr_panel;
  logic [RW-1:0]    wr_row;
  logic [W-1:0]     wr_data;
  logic             serial_clk, latch_enable, output_enable_n, swap_pending, frame_start;
  logic [LANES-1:0] serial_data_out;
  logic [ROWS-1:0]  row_select_n;
  logic [2:0]       unused_state_dbg;

  logic [W-1:0]     bank_m [2][NUM_PANELS][ROWS];
  logic             front_m;
  logic             tp_exp;
  logic [LANES-1:0] exp_q[$];
  int               errors = 0;
  int               checks = 0;

  led_panel_scanner #(
    .NUM_PANELS(NUM_PANELS), .COLORS(COLORS), .ROWS(ROWS), .COLS(COLS),
    .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES), .ON_CYCLES(ON_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_panel(wr_panel), .wr_row(wr_row),
    .wr_data(wr_data), .swap_req(swap_req), .test_mode(test_mode),
    .serial_clk(serial_clk), .serial_data_out(serial_data_out), .latch_enable(latch_enable),
    .output_enable_n(output_enable_n), .row_select_n(row_select_n),
    .swap_pending(swap_pending), .frame_start(frame_start), .state_dbg(unused_state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // drivers
  function automatic logic [W-1:0] rand_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic write_word(input int p, input int r, input logic [W-1:0] d);
    wr_en    = 1'b1;
    wr_panel = PW'(p);
    wr_row   = RW'(r);
    wr_data  = d;
    @(negedge clk);
    wr_en = 1'b0;
    bank_m[!front_m][p][r] = d;
  endtask

  task automatic fill_back_bank(input bit mark_a5);
    logic [W-1:0] d;
    for (int p = 0; p < NUM_PANELS; p++) begin
      for (int r = 0; r < ROWS; r++) begin
        d = rand_word();
        if (mark_a5 && p == 0 && r == 0) d[COLS-1:0] = 16'hA5A5;
        write_word(p, r, d);
      end
    end
  endtask

  task automatic wait_frame_start(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < FRAME_CYC + ROW_CYC);
    if (frame_start !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s: frame_start timeout got=%b exp=1", tag, frame_start);
    end
  endtask

  // scoreboard: expected lane vectors queued from the bank model, popped at each serial_clk rise
  task automatic check_row(input string tag, input int row, input bit wait_fs,
                           output logic [COLS-1:0] lane0);
    logic [LANES-1:0] v, got, exp;
    int latches, bits, cyc;
    logic prev;
    latches = 0; bits = 0; cyc = 0; prev = 1'b1; lane0 = '0;
    if (wait_fs) wait_frame_start(tag);
    for (int k = COLS - 1; k >= 0; k--) begin
      for (int p = 0; p < NUM_PANELS; p++)
        for (int c = 0; c < COLORS; c++)
          v[p*COLORS + c] = tp_exp | bank_m[front_m][p][row][c*COLS + k];
      exp_q.push_back(v);
    end
    while (bits < COLS && cyc < FRAME_CYC) begin
      if (latch_enable === 1'b1) latches++;
      if (latches == row && serial_clk === 1'b1 && prev === 1'b0) begin
        exp = exp_q.pop_front();
        got = serial_data_out;
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s row%0d col%0d: got=%h exp=%h", tag, row, COLS - 1 - bits, got, exp);
        end
        lane0[COLS - 1 - bits] = got[0];
        bits++;
      end
      prev = serial_clk;
      @(negedge clk);
      cyc++;
    end
    if (bits < COLS) begin
      checks++; errors++;
      $display("FAIL %s row%0d: only %0d of %0d bits seen", tag, row, bits, COLS);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (serial_clk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got=%b exp=0", serial_clk); end
    checks++; if (serial_data_out !== '0) begin errors++; $display("FAIL rst_data: got=%h exp=0", serial_data_out); end
    checks++; if (latch_enable !== 1'b0) begin errors++; $display("FAIL rst_latch: got=%b exp=0", latch_enable); end
    checks++; if (output_enable_n !== 1'b1) begin errors++; $display("FAIL rst_oe_n: got=%b exp=1", output_enable_n); end
    checks++; if (row_select_n !== 16'hFFFF) begin errors++; $display("FAIL rst_row_sel: got=%h exp=ffff", row_select_n); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL rst_pending: got=%b exp=0", swap_pending); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start: got=%b exp=0", frame_start); end
    reset = 1'b0;
    front_m = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 3);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++; $display("FAIL rst_release_frame_start: got=%b exp=1 after %0d cycles", frame_start, n);
    end
  endtask

  // cycle-exact trace of the first two rows after reset, starting on the frame_start cycle
  task automatic test_row_timing();
    int bad_sclk, bad_latch, bad_oe, bad_sel, bad_fs;
    int first_sclk, first_latch, first_oe, first_sel, first_fs;
    int row, off;
    logic e_sclk, e_latch, e_oe, e_fs;
    logic [ROWS-1:0] e_sel;
    bad_sclk = 0; bad_latch = 0; bad_oe = 0; bad_sel = 0; bad_fs = 0;
    first_sclk = -1; first_latch = -1; first_oe = -1; first_sel = -1; first_fs = -1;
    for (int i = 0; i < 2 * ROW_CYC; i++) begin
      row     = i / ROW_CYC;
      off     = i % ROW_CYC;
      e_sclk  = (off < SHIFT_CYC) && ((off % (2 * CLK_DIV)) >= CLK_DIV);
      e_latch = (off == LATCH_OFF);
      e_fs    = (i == 0);
      if (off < SHIFT_CYC) e_oe = (row == 0);
      else                 e_oe = (off < DISP_OFF);
      if (row == 0) e_sel = (off < LATCH_OFF) ? 16'hFFFF : 16'hFFFE;
      else          e_sel = (off < LATCH_OFF) ? 16'hFFFE : 16'hFFFD;
      if (serial_clk !== e_sclk)      begin bad_sclk++;  if (first_sclk  < 0) first_sclk  = i; end
      if (latch_enable !== e_latch)   begin bad_latch++; if (first_latch < 0) first_latch = i; end
      if (output_enable_n !== e_oe)   begin bad_oe++;    if (first_oe    < 0) first_oe    = i; end
      if (row_select_n !== e_sel)     begin bad_sel++;   if (first_sel   < 0) first_sel   = i; end
      if (frame_start !== e_fs)       begin bad_fs++;    if (first_fs    < 0) first_fs    = i; end
      @(negedge clk);
    end
    checks++; if (bad_sclk != 0)  begin errors++; $display("FAIL timing_sclk: got %0d bad cycles exp 0, first at %0d", bad_sclk, first_sclk); end
    checks++; if (bad_latch != 0) begin errors++; $display("FAIL timing_latch: got %0d bad cycles exp 0, first at %0d", bad_latch, first_latch); end
    checks++; if (bad_oe != 0)    begin errors++; $display("FAIL timing_oe_n: got %0d bad cycles exp 0, first at %0d", bad_oe, first_oe); end
    checks++; if (bad_sel != 0)   begin errors++; $display("FAIL timing_row_sel: got %0d bad cycles exp 0, first at %0d", bad_sel, first_sel); end
    checks++; if (bad_fs != 0)    begin errors++; $display("FAIL timing_frame_start: got %0d bad cycles exp 0, first at %0d", bad_fs, first_fs); end
  endtask

  task automatic test_swap_data();
    logic [COLS-1:0] l0;
    fill_back_bank(1'b1);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL swap_pending_set: got=%b exp=1", swap_pending); end
    wait_frame_start("swap_wait");
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL swap_pending_clr: got=%b exp=0", swap_pending); end
    front_m = ~front_m;
    check_row("swap_row0", 0, 1'b0, l0);
    checks++; if (l0 !== 16'hA5A5) begin errors++; $display("FAIL swap_lane0_a5a5: got=%h exp=a5a5", l0); end
    check_row("swap_row9", 9, 1'b1, l0);
  endtask

  task automatic test_front_write();
    logic [COLS-1:0] l0;
    fill_back_bank(1'b0);
    check_row("front_hold", 0, 1'b1, l0);
  endtask

  task automatic test_swap_edge();
    logic [COLS-1:0] l0;
    logic [W-1:0] d;
    bit pend_seen;
    wait_frame_start("edge_sync");
    repeat (FRAME_CYC - 1) @(negedge clk);
    d = rand_word();
    swap_req = 1'b1;
    wr_en = 1'b1; wr_panel = PW'(1); wr_row = RW'(2); wr_data = d;
    @(negedge clk);
    swap_req = 1'b0; wr_en = 1'b0;
    bank_m[!front_m][1][2] = d;
    front_m = ~front_m;
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL edge_frame_len: frame_start got=%b exp=1", frame_start); end
    pend_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (swap_pending !== 1'b0) pend_seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (pend_seen) begin errors++; $display("FAIL edge_pending: got=1 exp=0"); end
    check_row("edge_write", 2, 1'b1, l0);
  endtask

  task automatic test_back_to_back();
    logic [COLS-1:0] l0;
    wait_frame_start("b2b_sync");
    repeat (20) @(negedge clk);
    swap_req = 1'b1;
    repeat (2) @(negedge clk);
    swap_req = 1'b0;
    repeat (10) @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL b2b_pending_set: got=%b exp=1", swap_pending); end
    wait_frame_start("b2b_wait");
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL b2b_pending_clr: got=%b exp=0", swap_pending); end
    front_m = ~front_m;
    check_row("b2b_row3", 3, 1'b0, l0);
    check_row("b2b_hold", 3, 1'b1, l0);
  endtask

  task automatic test_test_mode();
    logic [COLS-1:0] l0;
    test_mode = 1'b1;
`ifdef TEST_PATTERN_EN
    tp_exp = 1'b1;
`else
    tp_exp = 1'b0;
`endif
    check_row("test_mode", 4, 1'b1, l0);
    test_mode = 1'b0;
    tp_exp = 1'b0;
  endtask

  task automatic test_reset_mid_row();
    logic [COLS-1:0] l0;
    wait_frame_start("rst_mid_sync");
    repeat (20) @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL rst_mid_pending_set: got=%b exp=1", swap_pending); end
    repeat (129) @(negedge clk);
    checks++; if (output_enable_n !== 1'b0) begin errors++; $display("FAIL rst_mid_displaying: oe_n got=%b exp=0", output_enable_n); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (output_enable_n !== 1'b1) begin errors++; $display("FAIL rst_mid_oe_n: got=%b exp=1", output_enable_n); end
    checks++; if (row_select_n !== 16'hFFFF) begin errors++; $display("FAIL rst_mid_row_sel: got=%h exp=ffff", row_select_n); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL rst_mid_pending: got=%b exp=0", swap_pending); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    front_m = 1'b0;
    check_row("rst_keep_bank", 0, 1'b1, l0);
    check_row("rst_no_swap", 1, 1'b1, l0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_panel = '0; wr_row = '0; wr_data = '0;
    swap_req = 1'b0; test_mode = 1'b0; tp_exp = 1'b0; front_m = 1'b0;
    test_reset();
    test_row_timing();
    test_swap_data();
    test_front_write();
    test_swap_edge();
    test_back_to_back();
    test_test_mode();
    test_reset_mid_row();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
